// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (start bit, 8 data bits LSB first, stop bit).
// Bit period is BAUD_COUNT+1 clk cycles; the start bit is qualified at its
// middle, and every later bit is sampled one bit period after the previous one.
// Optional build macro: UART_RX_MAJORITY_EN -- each sample becomes a 2-of-3
// vote over three consecutive synchronized samples centred on the mid-bit point.
// The decision is taken one cycle later. Requires BAUD_COUNT >= 4.
module uart_rx #(
  parameter int BAUD_COUNT      = 5207,
  parameter int HALF_BAUD_COUNT = BAUD_COUNT / 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RX_LINE,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Data and stop bits are decided when the counter reaches the full bit count.
  // The start-bit decision point moves one cycle later when majority voting is
  // enabled. That shifts the counter phase for the whole frame by one cycle, so
  // the three-sample window still straddles the true mid-bit point.
  localparam logic [15:0] BIT_END = 16'(BAUD_COUNT);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] START_POINT = 16'(HALF_BAUD_COUNT + 1);
`else
  localparam logic [15:0] START_POINT = 16'(HALF_BAUD_COUNT);
`endif

  logic        rx_meta_reg;
  logic        rx_s_reg;
  logic        rx_d_reg;
`ifdef UART_RX_MAJORITY_EN
  logic        rx_d2_reg;
`endif
  logic        falling_edge;
  logic        sample_bit;

  state_t      state_reg,   state_next;
  logic [15:0] counter_reg, counter_next;
  logic [2:0]  index_reg,   index_next;
  logic [7:0]  shift_reg,   shift_next;
  logic [7:0]  data_reg,    data_next;
  logic        valid_reg,   valid_next;
  logic        ferr_reg,    ferr_next;

  // Synchronize the asynchronous line and keep history for edge detection and voting.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_d_reg    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_d2_reg   <= 1'b1;
`endif
    end else begin
      rx_meta_reg <= RX_LINE;
      rx_s_reg    <= rx_meta_reg;
      rx_d_reg    <= rx_s_reg;
`ifdef UART_RX_MAJORITY_EN
      rx_d2_reg   <= rx_d_reg;
`endif
    end
  end

  // A falling edge needs a high history bit. A line stuck low after a break
  // therefore cannot retrigger until it has returned high.
  assign falling_edge = rx_d_reg & ~rx_s_reg;

`ifdef UART_RX_MAJORITY_EN
  assign sample_bit = (rx_d2_reg & rx_d_reg) | (rx_d2_reg & rx_s_reg) | (rx_d_reg & rx_s_reg);
`else
  assign sample_bit = rx_s_reg;
`endif

  // Receiver state, counters and output registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      counter_reg <= 16'd0;
      index_reg   <= 3'd0;
      shift_reg   <= 8'h00;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      index_reg   <= index_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  // Next-state logic: count within the current bit, and act at each sample point.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg + 16'd1;
    index_next   = index_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        counter_next = 16'd0;
        index_next   = 3'd0;
        if (falling_edge) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (counter_reg == START_POINT) begin
          counter_next = 16'd0;
          index_next   = 3'd0;
          // A line that is high again at mid-start was a glitch; drop it silently.
          state_next   = sample_bit ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (counter_reg == BIT_END) begin
          counter_next          = 16'd0;
          shift_next[index_reg] = sample_bit;
          if (index_reg == 3'd7) begin
            index_next = 3'd0;
            state_next = S_STOP;
          end else begin
            index_next = index_reg + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (counter_reg == BIT_END) begin
          counter_next = 16'd0;
          state_next   = S_IDLE;
          if (sample_bit) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next   = S_IDLE;
        counter_next = 16'd0;
        index_next   = 3'd0;
      end
    endcase
  end

  assign DATA       = data_reg;
  assign DATA_VALID = valid_reg;
  assign FRAME_ERR  = ferr_reg;
  assign BUSY       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx with BAUD_COUNT=15 (16-cycle bits).
// Each scenario task drives the line and checks its own expected values.
module tb_uart_rx;

  logic       clk;
  logic       RST;
  logic       RX_LINE;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  int checks = 0;
  int fails  = 0;

  // Monitor state, written only by the monitor processes below
  int         cyc      = 0;
  int         dv_cnt   = 0;
  int         fe_cnt   = 0;
  int         busy_cnt = 0;
  int         both_cnt = 0;
  int         dv_cyc_q[$];
  logic [7:0] dv_data_q[$];

`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  uart_rx #(.BAUD_COUNT(15), .HALF_BAUD_COUNT(7)) dut (
    .clk(clk),
    .RST(RST),
    .RX_LINE(RX_LINE),
    .DATA(DATA),
    .DATA_VALID(DATA_VALID),
    .FRAME_ERR(FRAME_ERR),
    .BUSY(BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Count pulses and busy cycles, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (DATA_VALID) begin
      dv_cnt++;
      dv_cyc_q.push_back(cyc);
      dv_data_q.push_back(DATA);
    end
    if (FRAME_ERR) fe_cnt++;
    if (BUSY) busy_cnt++;
    if (DATA_VALID && FRAME_ERR) both_cnt++;
  end

  // One bit period; optional one-cycle inversion at the mid-bit sample edge.
  task automatic send_bit(input logic v, input logic glitch);
    for (int i = 0; i < 16; i++) begin
      RX_LINE = (glitch && i == 8) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic [7:0] gmask);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], gmask[i]);
    send_bit(stop_v, 1'b0);
  endtask

  task automatic idle(input int n);
    RX_LINE = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (DATA !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", DATA); end
    checks++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", DATA_VALID); end
    checks++; if (FRAME_ERR !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    $display("reset: DATA=%h DATA_VALID=%b FRAME_ERR=%b BUSY=%b", DATA, DATA_VALID, FRAME_ERR, BUSY);
  endtask

  task automatic test_frame_a5();
    int n0, f0, b0, start_cyc, lat;
    idle(5);
    n0 = dv_cnt; f0 = fe_cnt; b0 = busy_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 8'h00);
    idle(20);
    checks++; if (dv_cnt - n0 !== 1) begin fails++; $display("FAIL a5_pulses: got %0d want 1", dv_cnt - n0); end
    if (dv_cnt - n0 >= 1) begin
      checks++; if (dv_data_q[n0] !== 8'hA5) begin fails++; $display("FAIL a5_data: got %h want a5", dv_data_q[n0]); end
      lat = dv_cyc_q[n0] - start_cyc - 1;
      checks++;
      if (lat < 153 + EXTRA || lat > 155 + EXTRA) begin
        fails++; $display("FAIL a5_latency: got %0d want %0d+-1", lat, 154 + EXTRA);
      end
    end
    checks++; if (DATA !== 8'hA5) begin fails++; $display("FAIL a5_hold: got %h want a5", DATA); end
    checks++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL a5_ferr: got %0d want 0", fe_cnt - f0); end
    checks++;
    if (busy_cnt - b0 < 151 + EXTRA || busy_cnt - b0 > 153 + EXTRA) begin
      fails++; $display("FAIL a5_busy: got %0d cycles want %0d+-1", busy_cnt - b0, 152 + EXTRA);
    end
    $display("frame a5: DATA=%h pulses=%0d busy_cycles=%0d", DATA, dv_cnt - n0, busy_cnt - b0);
  endtask

  task automatic test_glitch();
    int n0, f0, b0;
    n0 = dv_cnt; f0 = fe_cnt; b0 = busy_cnt;
    RX_LINE = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(25);
    checks++;
    if (busy_cnt - b0 < 7 || busy_cnt - b0 > 12) begin
      fails++; $display("FAIL glitch_busy: got %0d cycles want 7..12", busy_cnt - b0);
    end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", BUSY); end
    checks++;
    if (dv_cnt - n0 !== 0 || fe_cnt - f0 !== 0) begin
      fails++; $display("FAIL glitch_pulse: got dv=%0d fe=%0d want 0 0", dv_cnt - n0, fe_cnt - f0);
    end
    checks++; if (DATA !== 8'hA5) begin fails++; $display("FAIL glitch_data: got %h want a5", DATA); end
    $display("glitch: busy_cycles=%0d DATA=%h", busy_cnt - b0, DATA);
  endtask

  task automatic test_break();
    int n0, f0;
    logic [7:0] b;
    b = 8'h3C;
    n0 = dv_cnt; f0 = fe_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    RX_LINE = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 30) begin
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL break_retrigger: busy=%b want 0", BUSY); end
      end
      @(posedge clk); #1;
    end
    idle(40);
    checks++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL break_ferr: got %0d want 1", fe_cnt - f0); end
    checks++; if (dv_cnt - n0 !== 0) begin fails++; $display("FAIL break_valid: got %0d want 0", dv_cnt - n0); end
    checks++; if (DATA !== 8'hA5) begin fails++; $display("FAIL break_data: got %h want a5", DATA); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL break_busy: got %b want 0", BUSY); end
    $display("break: ferr_pulses=%0d DATA=%h", fe_cnt - f0, DATA);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = dv_cnt;
    send_frame(8'h00, 1'b1, 8'h00);
    send_frame(8'hFF, 1'b1, 8'h00);
    idle(20);
    checks++; if (dv_cnt - n0 !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", dv_cnt - n0); end
    if (dv_cnt - n0 >= 2) begin
      checks++; if (dv_data_q[n0] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", dv_data_q[n0]); end
      checks++; if (dv_data_q[n0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", dv_data_q[n0+1]); end
      checks++;
      if (dv_cyc_q[n0+1] - dv_cyc_q[n0] !== 160) begin
        fails++; $display("FAIL b2b_spacing: got %0d want 160", dv_cyc_q[n0+1] - dv_cyc_q[n0]);
      end
    end
    $display("back-to-back: pulses=%0d DATA=%h", dv_cnt - n0, DATA);
  endtask

  task automatic test_reset_midframe();
    int n0, f0;
    logic [7:0] b;
    b = 8'h81;
    n0 = dv_cnt; f0 = fe_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
    RST = 1'b1;
    #1;
    checks++; if (DATA !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h want 00", DATA); end
    checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    checks++;
    if (DATA_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      fails++; $display("FAIL rstmid_pulse: got dv=%b fe=%b want 0 0", DATA_VALID, FRAME_ERR);
    end
    RX_LINE = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    idle(200);
    checks++;
    if (dv_cnt - n0 !== 0 || fe_cnt - f0 !== 0) begin
      fails++; $display("FAIL rstmid_partial: got dv=%0d fe=%0d want 0 0", dv_cnt - n0, fe_cnt - f0);
    end
    send_frame(8'h5A, 1'b1, 8'h00);
    idle(20);
    checks++; if (dv_cnt - n0 !== 1) begin fails++; $display("FAIL rstmid_next_pulses: got %0d want 1", dv_cnt - n0); end
    checks++; if (DATA !== 8'h5A) begin fails++; $display("FAIL rstmid_next_data: got %h want 5a", DATA); end
    $display("reset mid-frame: then DATA=%h", DATA);
  endtask

  task automatic test_majority_glitch();
    int n0;
    logic [7:0] expect_data;
`ifdef UART_RX_MAJORITY_EN
    expect_data = 8'hF0;
`else
    expect_data = 8'h71;
`endif
    n0 = dv_cnt;
    send_frame(8'hF0, 1'b1, 8'h81);
    idle(20);
    checks++; if (dv_cnt - n0 !== 1) begin fails++; $display("FAIL maj_pulses: got %0d want 1", dv_cnt - n0); end
    checks++; if (DATA !== expect_data) begin fails++; $display("FAIL maj_data: got %h want %h", DATA, expect_data); end
    $display("mid-bit glitch frame f0: DATA=%h", DATA);
  endtask

  initial begin
    RST     = 1'b1;
    RX_LINE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    RST = 1'b0;
    test_frame_a5();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_majority_glitch();
    checks++; if (both_cnt !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
